// File: rtl/prim_fifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// prim_fifo_arb_pkg
// Shared types for the FIFO write-side arbiter family.
// Contents:
//   arb_state_e : arbiter FSM state (idle/arbitrating vs. burst in progress)
// ---------------------------------------------------------------------------
package prim_fifo_arb_pkg;

    typedef enum logic [0:0] {
        ArbIdle  = 1'b0,
        ArbBurst = 1'b1
    } arb_state_e;

endpackage

// File: rtl/prim_rr_pick.sv
// ---------------------------------------------------------------------------
// prim_rr_pick
// Combinational round-robin picker. Scans ptr+1, ptr+2, ... modulo N and
// returns the first set bit of valid, so the entry at ptr itself has the
// lowest priority.
// Ports:
//   valid [N]    : candidate request vector
//   ptr   [IdxW] : index served last
//   found        : at least one candidate is valid
//   idx   [IdxW] : chosen candidate (0 when nothing is found)
// ---------------------------------------------------------------------------
module prim_rr_pick #(
    parameter int N    = 4,
    parameter int IdxW = $clog2(N)
) (
    input  logic [N-1:0]    valid,
    input  logic [IdxW-1:0] ptr,
    output logic            found,
    output logic [IdxW-1:0] idx
);

    logic [IdxW-1:0] cand;

    // Walk from the farthest offset back to the nearest one, so the nearest
    // valid candidate after ptr is the one left in idx.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int off = N; off >= 1; off--) begin
            cand = IdxW'((int'(ptr) + off) % N);
            if (valid[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/prim_fifo_wr_arb.sv
// ---------------------------------------------------------------------------
// prim_fifo_wr_arb
// Round-robin arbiter sharing the write port of an async FIFO among N
// requesters. A grant lasts up to MaxBurst beats or until the requester's
// last beat; a new burst starts only when the FIFO has MinSpace free entries.
// Ports:
//   clk_i, rst_ni      : FIFO write clock, async active-low reset
//   req_valid_i [N]    : per-requester valid
//   req_ready_o [N]    : per-requester ready (only the granted one can be 1)
//   req_data_i  [N*W]  : requester k at [k*Width +: Width]
//   req_last_i  [N]    : final beat of a requester packet
//   fifo_wvalid_o      : FIFO write valid
//   fifo_wready_i      : FIFO write ready
//   fifo_wdata_o [W]   : FIFO write data
//   fifo_wdepth_i      : FIFO occupancy seen from the write side
//   gnt_idx_o          : current or most recently granted requester
//   busy_o             : burst in progress
// ---------------------------------------------------------------------------
module prim_fifo_wr_arb
    import prim_fifo_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int Width    = 16,
    parameter int Depth    = 3,
    parameter int DepthW   = $clog2(Depth + 1),
    parameter int MaxBurst = 4,
    parameter int MinSpace = 1,
    parameter int IdxW     = $clog2(N)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [N-1:0]         req_valid_i,
    output logic [N-1:0]         req_ready_o,
    input  logic [N*Width-1:0]   req_data_i,
    input  logic [N-1:0]         req_last_i,
    output logic                 fifo_wvalid_o,
    input  logic                 fifo_wready_i,
    output logic [Width-1:0]     fifo_wdata_o,
    input  logic [DepthW-1:0]    fifo_wdepth_i,
    output logic [IdxW-1:0]      gnt_idx_o,
    output logic                 busy_o
);

    localparam int BeatW  = $clog2(MaxBurst + 1);
    localparam int SpaceW = DepthW + 1;

    arb_state_e       state;
    logic [IdxW-1:0]  gnt_idx;
    logic [IdxW-1:0]  rr_ptr;
    logic [BeatW-1:0] beat_cnt;

    logic             pick_found;
    logic [IdxW-1:0]  pick_idx;
    logic             busy;
    logic             beat;
    logic             burst_end;

    logic [SpaceW-1:0] depth_ext;
    logic [SpaceW-1:0] free_cnt;
    logic              space_ok;

    logic [Width-1:0] data_arr [N];

    prim_rr_pick #(
        .N    (N),
        .IdxW (IdxW)
    ) u_pick (
        .valid (req_valid_i),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // One extra bit keeps the subtraction from wrapping; an occupancy above
    // Depth is treated as a full FIFO.
    assign depth_ext = {1'b0, fifo_wdepth_i};
    assign free_cnt  = SpaceW'(Depth) - depth_ext;
    assign space_ok  = (depth_ext <= SpaceW'(Depth)) && (free_cnt >= SpaceW'(MinSpace));

    assign busy      = (state == ArbBurst);
    assign beat      = fifo_wvalid_o && fifo_wready_i;
    assign burst_end = beat && (req_last_i[gnt_idx] || (beat_cnt == BeatW'(MaxBurst - 1)));

    always_comb begin
        for (int k = 0; k < N; k++) begin
            data_arr[k] = req_data_i[k*Width +: Width];
        end
    end

    // Data and valid are a straight pass-through from the granted requester.
    assign fifo_wdata_o  = data_arr[gnt_idx];
    assign fifo_wvalid_o = busy && req_valid_i[gnt_idx];

    always_comb begin
        req_ready_o = '0;
        if (busy) begin
            req_ready_o[gnt_idx] = fifo_wready_i;
        end
    end

    assign gnt_idx_o = gnt_idx;
    assign busy_o    = busy;

    // rr_ptr resets to N-1 so requester 0 is first in line after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= ArbIdle;
            gnt_idx  <= '0;
            rr_ptr   <= IdxW'(N - 1);
            beat_cnt <= '0;
        end else begin
            case (state)
                ArbIdle: begin
                    if (pick_found && space_ok) begin
                        gnt_idx  <= pick_idx;
                        beat_cnt <= '0;
                        state    <= ArbBurst;
                    end
                end
                ArbBurst: begin
                    if (burst_end) begin
                        rr_ptr   <= gnt_idx;
                        beat_cnt <= '0;
                        state    <= ArbIdle;
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= ArbIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_prim_fifo_wr_arb.sv
// ---------------------------------------------------------------------------
// tb_prim_fifo_wr_arb
// Self-checking bench for prim_fifo_wr_arb (N=4, Width=16, Depth=3,
// MaxBurst=4, MinSpace=2): a hand-derived vector table, directed sequences
// for streaming, backpressure and reset mid-burst, then random traffic
// compared against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_prim_fifo_wr_arb;

    localparam int N        = 4;
    localparam int Width    = 16;
    localparam int Depth    = 3;
    localparam int DepthW   = 2;
    localparam int MaxBurst = 4;
    localparam int MinSpace = 2;
    localparam int IdxW     = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_ready;
    logic [N*Width-1:0]  req_data;
    logic [N-1:0]        req_last;
    logic                fifo_wvalid;
    logic                fifo_wready;
    logic [Width-1:0]    fifo_wdata;
    logic [DepthW-1:0]   fifo_wdepth;
    logic [IdxW-1:0]     gnt_idx;
    logic                busy;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: whether a grant is open, who holds it, who was served
    // last, and how many beats the open grant has moved.
    bit m_busy;
    int m_gnt;
    int m_last;
    int m_beats;

    typedef struct {
        logic [N-1:0]      valid;
        logic [N-1:0]      last;
        logic              wready;
        logic [DepthW-1:0] wdepth;
        logic              exp_busy;
        logic [IdxW-1:0]   exp_gnt;
        logic              exp_wvalid;
        logic [N-1:0]      exp_ready;
    } vec_t;

    vec_t vecs [19];

    prim_fifo_wr_arb #(
        .N        (N),
        .Width    (Width),
        .Depth    (Depth),
        .DepthW   (DepthW),
        .MaxBurst (MaxBurst),
        .MinSpace (MinSpace),
        .IdxW     (IdxW)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_data_i    (req_data),
        .req_last_i    (req_last),
        .fifo_wvalid_o (fifo_wvalid),
        .fifo_wready_i (fifo_wready),
        .fifo_wdata_o  (fifo_wdata),
        .fifo_wdepth_i (fifo_wdepth),
        .gnt_idx_o     (gnt_idx),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [N-1:0] valid, input logic [N-1:0] last,
                                 input logic wready, input logic [DepthW-1:0] wdepth);
        req_valid   = valid;
        req_last    = last;
        fifo_wready = wready;
        fifo_wdepth = wdepth;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic modelReset();
        m_busy  = 1'b0;
        m_gnt   = 0;
        m_last  = N - 1;
        m_beats = 0;
    endtask

    // Apply the clock-edge rules to the model using the inputs held this cycle.
    task automatic modelStep();
        int c;
        if (!m_busy) begin
            if (req_valid != '0 && int'(fifo_wdepth) <= Depth &&
                (Depth - int'(fifo_wdepth)) >= MinSpace) begin
                for (int d = 1; d <= N; d++) begin
                    c = (m_last + d) % N;
                    if (req_valid[c]) begin
                        m_gnt = c;
                        break;
                    end
                end
                m_busy  = 1'b1;
                m_beats = 0;
            end
        end else if (req_valid[m_gnt] && fifo_wready) begin
            m_beats++;
            if (req_last[m_gnt] || m_beats == MaxBurst) begin
                m_busy  = 1'b0;
                m_last  = m_gnt;
                m_beats = 0;
            end
        end
    endtask

    task automatic modelCheck();
        logic [N-1:0] exp_ready;
        exp_ready = '0;
        if (m_busy) exp_ready[m_gnt] = fifo_wready;
        checkOutput("mdl_busy", 64'(busy), 64'(m_busy));
        checkOutput("mdl_gnt", 64'(gnt_idx), 64'(m_gnt));
        checkOutput("mdl_wvalid", 64'(fifo_wvalid), 64'(m_busy && req_valid[m_gnt]));
        checkOutput("mdl_ready", 64'(req_ready), 64'(exp_ready));
        checkOutput("mdl_wdata", 64'(fifo_wdata), 64'(req_data[m_gnt*Width +: Width]));
    endtask

    task automatic settle();
        #2;
        modelCheck();
    endtask

    task automatic advance();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        applyStimulus('0, '0, 1'b1, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelReset();
        #1;
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_gnt", 64'(gnt_idx), 64'd0);
        checkOutput("rst_wvalid", 64'(fifo_wvalid), 64'd0);
        checkOutput("rst_ready", 64'(req_ready), 64'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int exp_g [5];
        int exp_l [5];
        int burst_gnt [$];
        int burst_len [$];
        int sent0;
        bit prev_busy;
        bit done;

        // Reset priority, fairness, space gate, stall and valid drop.
        vecs[0]  = '{4'b0110, 4'b1111, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 4'b0000};
        vecs[1]  = '{4'b0110, 4'b1111, 1'b1, 2'd0, 1'b1, 2'd1, 1'b1, 4'b0010};
        vecs[2]  = '{4'b0110, 4'b1111, 1'b1, 2'd0, 1'b0, 2'd1, 1'b0, 4'b0000};
        vecs[3]  = '{4'b0110, 4'b1111, 1'b1, 2'd0, 1'b1, 2'd2, 1'b1, 4'b0100};
        vecs[4]  = '{4'b1111, 4'b1111, 1'b1, 2'd0, 1'b0, 2'd2, 1'b0, 4'b0000};
        vecs[5]  = '{4'b1111, 4'b1111, 1'b1, 2'd0, 1'b1, 2'd3, 1'b1, 4'b1000};
        vecs[6]  = '{4'b1111, 4'b1111, 1'b1, 2'd0, 1'b0, 2'd3, 1'b0, 4'b0000};
        vecs[7]  = '{4'b1111, 4'b1111, 1'b1, 2'd0, 1'b1, 2'd0, 1'b1, 4'b0001};
        vecs[8]  = '{4'b1111, 4'b1111, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 4'b0000};
        vecs[9]  = '{4'b1111, 4'b1111, 1'b1, 2'd0, 1'b1, 2'd1, 1'b1, 4'b0010};
        vecs[10] = '{4'b1111, 4'b1111, 1'b1, 2'd2, 1'b0, 2'd1, 1'b0, 4'b0000};
        vecs[11] = '{4'b1111, 4'b1111, 1'b1, 2'd3, 1'b0, 2'd1, 1'b0, 4'b0000};
        vecs[12] = '{4'b1111, 4'b1111, 1'b1, 2'd1, 1'b0, 2'd1, 1'b0, 4'b0000};
        vecs[13] = '{4'b1111, 4'b1111, 1'b1, 2'd1, 1'b1, 2'd2, 1'b1, 4'b0100};
        vecs[14] = '{4'b0001, 4'b0000, 1'b1, 2'd0, 1'b0, 2'd2, 1'b0, 4'b0000};
        vecs[15] = '{4'b0001, 4'b0000, 1'b0, 2'd0, 1'b1, 2'd0, 1'b1, 4'b0000};
        vecs[16] = '{4'b0000, 4'b0000, 1'b1, 2'd0, 1'b1, 2'd0, 1'b0, 4'b0001};
        vecs[17] = '{4'b0001, 4'b0001, 1'b1, 2'd0, 1'b1, 2'd0, 1'b1, 4'b0001};
        vecs[18] = '{4'b0000, 4'b0000, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 4'b0000};

        req_data = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
        resetDut();
        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].last, vecs[i].wready, vecs[i].wdepth);
            #2;
            checkOutput($sformatf("row%0d_busy", i), 64'(busy), 64'(vecs[i].exp_busy));
            checkOutput($sformatf("row%0d_gnt", i), 64'(gnt_idx), 64'(vecs[i].exp_gnt));
            checkOutput($sformatf("row%0d_wvalid", i), 64'(fifo_wvalid), 64'(vecs[i].exp_wvalid));
            checkOutput($sformatf("row%0d_ready", i), 64'(req_ready), 64'(vecs[i].exp_ready));
            checkOutput($sformatf("row%0d_wdata", i), 64'(fifo_wdata),
                        64'(16'hD000 + 16'(vecs[i].exp_gnt)));
            @(posedge clk);
            #1;
        end

        // Requester 0 streams 10 beats while requester 2 sends 1-beat packets.
        resetDut();
        exp_g = '{0, 2, 0, 2, 0};
        exp_l = '{4, 1, 4, 1, 2};
        sent0 = 0;
        prev_busy = 1'b0;
        done = 1'b0;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            req_data = {16'h3333, 16'h2222, 16'h1111, 16'(16'h0100 + sent0)};
            applyStimulus({1'b0, 1'b1, 1'b0, 1'(sent0 < 10)}, {1'b0, 1'b1, 1'b0, 1'(sent0 == 9)},
                          1'b1, 2'd0);
            #2;
            if (busy && !prev_busy) begin
                burst_gnt.push_back(int'(gnt_idx));
                burst_len.push_back(0);
            end
            prev_busy = busy;
            if (fifo_wvalid && fifo_wready && burst_len.size() > 0) begin
                burst_len[burst_len.size() - 1]++;
                if (gnt_idx == 2'd0) begin
                    checkOutput("stream_data", 64'(fifo_wdata), 64'(16'h0100 + sent0));
                    sent0++;
                end
            end
            @(posedge clk);
            #1;
            if (sent0 == 10 && !busy) done = 1'b1;
        end
        checkOutput("stream_done", 64'(done), 64'd1);
        checkOutput("stream_bursts", 64'(burst_gnt.size()), 64'd5);
        for (int i = 0; i < 5 && i < burst_gnt.size(); i++) begin
            checkOutput($sformatf("stream_gnt%0d", i), 64'(burst_gnt[i]), 64'(exp_g[i]));
            checkOutput($sformatf("stream_len%0d", i), 64'(burst_len[i]), 64'(exp_l[i]));
        end

        // Backpressure: three stalled cycles after the first beat of a burst.
        resetDut();
        req_data = {16'h4444, 16'h3333, 16'h1000, 16'h1111};
        applyStimulus(4'b0010, 4'b0000, 1'b1, 2'd0);
        settle();
        advance();
        settle();
        checkOutput("bp_first_busy", 64'(busy), 64'd1);
        advance();
        req_data[31:16] = 16'h1001;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0010, 4'b0000, 1'b0, 2'd0);
            settle();
            checkOutput("bp_stall_ready", 64'(req_ready), 64'd0);
            checkOutput("bp_stall_data", 64'(fifo_wdata), 64'h1001);
            checkOutput("bp_stall_busy", 64'(busy), 64'd1);
            advance();
        end
        for (int i = 1; i <= 3; i++) begin
            req_data[31:16] = 16'(16'h1000 + i);
            applyStimulus(4'b0010, 4'b0000, 1'b1, 2'd0);
            settle();
            checkOutput("bp_resume_ready", 64'(req_ready), 64'b0010);
            checkOutput("bp_resume_data", 64'(fifo_wdata), 64'(16'h1000 + i));
            advance();
        end
        applyStimulus(4'b0000, 4'b0000, 1'b1, 2'd0);
        settle();
        checkOutput("bp_burst_closed", 64'(busy), 64'd0);
        advance();

        // Reset asserted during the second beat of a burst.
        resetDut();
        req_data = {16'h4444, 16'h3333, 16'h2222, 16'hBEEF};
        applyStimulus(4'b0001, 4'b0000, 1'b1, 2'd0);
        settle();
        advance();
        settle();
        advance();
        #2;
        checkOutput("mid_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_wvalid", 64'(fifo_wvalid), 64'd0);
        checkOutput("mid_rst_ready", 64'(req_ready), 64'd0);
        checkOutput("mid_rst_busy", 64'(busy), 64'd0);
        checkOutput("mid_rst_gnt", 64'(gnt_idx), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelReset();
        applyStimulus(4'b1001, 4'b0000, 1'b1, 2'd0);
        settle();
        advance();
        checkOutput("mid_prio_gnt", 64'(gnt_idx), 64'd0);
        checkOutput("mid_prio_busy", 64'(busy), 64'd1);
        settle();
        advance();

        // Random traffic against the reference model.
        resetDut();
        for (int cyc = 0; cyc < 400; cyc++) begin
            req_data = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
            applyStimulus(4'($urandom), 4'($urandom & $urandom), 1'($urandom_range(3, 0) != 0),
                          2'($urandom_range(3, 0)));
            settle();
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/prim_fifo_wr_arb.md
# prim_fifo_wr_arb

Round-robin write-side arbiter that shares the single write port of an asynchronous FIFO among `N` requesters in the FIFO's write clock domain. It grants one requester at a time for a burst of up to `MaxBurst` beats, or until that requester's `last` beat. A new burst starts only when the FIFO reports at least `MinSpace` free entries. It sits directly in front of the async FIFO write interface (`wvalid`/`wready`/`wdata`/`wdepth`).

## Interface
- `N`, 4, number of requesters (≥2)
- `Width`, 16, data width
- `Depth`, 3, FIFO depth; must match the attached FIFO
- `DepthW`, `$clog2(Depth+1)`, width of the FIFO occupancy input
- `MaxBurst`, 4, maximum beats per grant (≥1)
- `MinSpace`, 1, free entries required to start a burst (1..Depth)
- `IdxW`, `$clog2(N)`, grant index width

Ports:
- `clk_i` in 1: FIFO write clock
- `rst_ni` in 1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `req_valid_i` in N: per-requester valid
- `req_ready_o` out N: per-requester ready
- `req_data_i` in N*Width: requester k occupies `[k*Width +: Width]`
- `req_last_i` in N: final beat of requester packet
- `fifo_wvalid_o` out 1: to FIFO `wvalid`
- `fifo_wready_i` in 1: from FIFO `wready`
- `fifo_wdata_o` out Width: to FIFO `wdata`
- `fifo_wdepth_i` in DepthW: from FIFO `wdepth`
- `gnt_idx_o` out IdxW: currently or last granted requester
- `busy_o` out 1: high in BURST

## Operation
- States: IDLE, BURST. Registers: `state`, `gnt_idx`, `rr_ptr` (last served), `beat_cnt` (`$clog2(MaxBurst+1)` bits).
- IDLE:
  - `fifo_wvalid_o=0`, `req_ready_o=0`.
  - If any `req_valid_i` and `Depth - fifo_wdepth_i >= MinSpace`, pick the first valid index scanning `rr_ptr+1, rr_ptr+2, …` modulo N.
  - Latch the pick into `gnt_idx` and clear `beat_cnt`.
  - Go to BURST.
- BURST (combinational pass-through, granted index g):
  - `fifo_wvalid_o = req_valid_i[g]`
  - `fifo_wdata_o = req_data_i[g]`
  - `req_ready_o[g] = fifo_wready_i`; all other ready bits 0.
- Beat = `fifo_wvalid_o & fifo_wready_i`. On each beat, `beat_cnt++`.
- Burst end: a beat with `req_last_i[g]=1`, or a beat with `beat_cnt == MaxBurst-1`. On burst end: `rr_ptr <= g`, go to IDLE.
- Requester dropping valid mid-burst: grant is held and the arbiter waits; no timeout.
- FIFO full mid-burst: stall via `fifo_wready_i`; the space check applies only at burst start.
- `fifo_wdata_o` in IDLE = `req_data_i[gnt_idx]` (don't-care; no X propagation required).

## Timing
- Arbitration costs one IDLE cycle between bursts. Peak throughput is `MaxBurst/(MaxBurst+1)`.
- Data and valid path: zero latency, combinational from requester to FIFO.
- Reset values:
  - `state=IDLE`, `gnt_idx=0`, `rr_ptr=N-1` (requester 0 has first priority), `beat_cnt=0`.
  - Outputs: `fifo_wvalid_o=0`, `req_ready_o=0`, `gnt_idx_o=0`, `busy_o=0`.
- Reset mid-burst aborts the burst immediately (asynchronous). A partial packet already in the FIFO is the requester's concern.
- Simultaneous `last` and MaxBurst-limit on the same beat: a single burst end.
- `rr_ptr` wraps from N-1 to 0. `beat_cnt` never exceeds `MaxBurst-1`.
- Occupancy compare uses DepthW+1-bit unsigned arithmetic; `fifo_wdepth_i > Depth` never occurs and is treated as "no space".

## Structure
- Package `prim_fifo_arb_pkg`: state enum (`ArbIdle`, `ArbBurst`).
- Sub-module `prim_rr_pick`: combinational, params `N`/`IdxW`, inputs `valid[N]` and `ptr`, outputs `found` and `idx`. Reused by other arbiters.
- Top: FSM, counters, output mux.

## Test plan
- **Reset priority:** after reset, requesters 1 and 2 valid, FIFO empty → grant 1 first (`gnt_idx_o=1`), then grant 2 after its burst, one idle cycle between.
- **Fairness:** N=4, all valid, `last=1` every beat, `wready=1` → grant order 0,1,2,3,0. Each burst is 1 beat with 1 idle cycle between.
- **Burst limit:** requester 0 streams 10 beats with `last=0`, MaxBurst=4 → bursts of 4,4,2. Any other valid requester is interleaved between bursts.
- **Space gate:** Depth=3, MinSpace=2, `wdepth=2`, requester valid → stays IDLE. Drop `wdepth` to 1 → BURST next cycle.
- **Backpressure:** `wready=0` for 3 cycles mid-burst → `req_ready_o[g]=0`, `beat_cnt` frozen, data held; the burst resumes intact.
- **Reset mid-burst:** assert `rst_ni=0` during beat 2 → all outputs 0 asynchronously; after release, requester 0 has priority.
